// File: rtl/lstm_weight_loader.sv
// lstm_weight_loader: sequences the initial load of all LSTM gate parameters
// (X/Y weight RAM columns and bias vectors for gates Z, I, F, O) from a
// word-serial stream. HIDDEN_SZ words are packed into one column, then a
// single-cycle write strobe targets the matching RAM or bias register.
// Optional trailing checksum beat is enabled by defining WLOAD_CHECKSUM_EN.
module lstm_weight_loader #(
  parameter int INPUT_SZ  = 2,
  parameter int HIDDEN_SZ = 16,
  parameter int QN        = 6,
  parameter int QM        = 11,
  localparam int BITWIDTH       = QN + QM + 1,
  localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
  localparam int XW             = $clog2(INPUT_SZ),
  localparam int YW             = $clog2(HIDDEN_SZ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [BITWIDTH-1:0]       inData_i,
  input  logic                      inValid_i,
  output logic                      inReady_o,
  output logic [LAYER_BITWIDTH-1:0] colData_o,
  output logic [XW-1:0]             colAddrX_o,
  output logic [YW-1:0]             colAddrY_o,
  output logic [3:0]                writeEnX_o,
  output logic [3:0]                writeEnY_o,
  output logic [3:0]                biasWrEn_o,
  output logic                      busy_o,
`ifdef WLOAD_CHECKSUM_EN
  output logic                      ckErr_o,
`endif
  output logic                      loadDone_o
);

  localparam int CW = (XW > YW) ? XW : YW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
`ifdef WLOAD_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd4;
`endif

  localparam logic [1:0] SEC_X = 2'd0;
  localparam logic [1:0] SEC_Y = 2'd1;
  localparam logic [1:0] SEC_B = 2'd2;

  localparam logic [YW-1:0] LAST_ELEM = YW'(HIDDEN_SZ - 1);
  localparam logic [CW-1:0] LAST_X    = CW'(INPUT_SZ - 1);
  localparam logic [CW-1:0] LAST_Y    = CW'(HIDDEN_SZ - 1);
  localparam logic [CW-1:0] COL_ONE   = CW'(1);
  localparam logic [YW-1:0] ELEM_ONE  = YW'(1);

  logic [2:0]                state_q, state_d;
  logic [YW-1:0]             elemCnt_q, elemCnt_d;
  logic [CW-1:0]             colCnt_q, colCnt_d;
  logic [1:0]                section_q, section_d;
  logic [1:0]                gate_q, gate_d;
  logic [LAYER_BITWIDTH-1:0] colData_q, colData_d;
  logic [XW-1:0]             colAddrX_q, colAddrX_d;
  logic [YW-1:0]             colAddrY_q, colAddrY_d;
  logic                      busy_q, busy_d;
  logic                      loadDone_q, loadDone_d;
`ifdef WLOAD_CHECKSUM_EN
  logic [BITWIDTH-1:0]       sum_q, sum_d;
  logic                      ckErr_q, ckErr_d;
`endif

  logic       transfer;
  logic       inWrite;
  logic [3:0] gateOneHot;

`ifdef WLOAD_CHECKSUM_EN
  assign inReady_o = (state_q == S_FILL) || (state_q == S_CHECK);
  assign ckErr_o   = ckErr_q;
`else
  assign inReady_o = (state_q == S_FILL);
`endif

  assign transfer   = inValid_i & inReady_o;
  assign inWrite    = (state_q == S_WRITE);
  assign gateOneHot = 4'b0001 << gate_q;

  assign writeEnX_o = (inWrite && section_q == SEC_X) ? gateOneHot : 4'b0000;
  assign writeEnY_o = (inWrite && section_q == SEC_Y) ? gateOneHot : 4'b0000;
  assign biasWrEn_o = (inWrite && section_q == SEC_B) ? gateOneHot : 4'b0000;

  assign colData_o  = colData_q;
  assign colAddrX_o = colAddrX_q;
  assign colAddrY_o = colAddrY_q;
  assign busy_o     = busy_q;
  assign loadDone_o = loadDone_q;

  // Next-state logic: column assembly, write sequencing and gate/section walk
  always_comb begin
    state_d    = state_q;
    elemCnt_d  = elemCnt_q;
    colCnt_d   = colCnt_q;
    section_d  = section_q;
    gate_d     = gate_q;
    colData_d  = colData_q;
    colAddrX_d = colAddrX_q;
    colAddrY_d = colAddrY_q;
    busy_d     = busy_q;
    loadDone_d = loadDone_q;
`ifdef WLOAD_CHECKSUM_EN
    sum_d      = sum_q;
    ckErr_d    = ckErr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_FILL;
          busy_d     = 1'b1;
          loadDone_d = 1'b0;
          elemCnt_d  = '0;
          colCnt_d   = '0;
          section_d  = SEC_X;
          gate_d     = 2'd0;
`ifdef WLOAD_CHECKSUM_EN
          sum_d      = '0;
          ckErr_d    = 1'b0;
`endif
        end
      end
      S_FILL: begin
        if (transfer) begin
          colData_d[32'(elemCnt_q) * BITWIDTH +: BITWIDTH] = inData_i;
          elemCnt_d = elemCnt_q + ELEM_ONE;
`ifdef WLOAD_CHECKSUM_EN
          sum_d     = sum_q + inData_i;
`endif
          if (elemCnt_q == LAST_ELEM) begin
            state_d = S_WRITE;
            if (section_q == SEC_X) colAddrX_d = colCnt_q[XW-1:0];
            if (section_q == SEC_Y) colAddrY_d = colCnt_q[YW-1:0];
          end
        end
      end
      S_WRITE: begin
        state_d = S_FILL;
        case (section_q)
          SEC_X: begin
            if (colCnt_q == LAST_X) begin
              section_d = SEC_Y;
              colCnt_d  = '0;
            end else begin
              colCnt_d = colCnt_q + COL_ONE;
            end
          end
          SEC_Y: begin
            if (colCnt_q == LAST_Y) begin
              section_d = SEC_B;
              colCnt_d  = '0;
            end else begin
              colCnt_d = colCnt_q + COL_ONE;
            end
          end
          default: begin
            colCnt_d  = '0;
            section_d = SEC_X;
            if (gate_q == 2'd3) begin
`ifdef WLOAD_CHECKSUM_EN
              state_d    = S_CHECK;
`else
              state_d    = S_DONE;
              busy_d     = 1'b0;
              loadDone_d = 1'b1;
`endif
            end else begin
              gate_d = gate_q + 2'd1;
            end
          end
        endcase
      end
`ifdef WLOAD_CHECKSUM_EN
      S_CHECK: begin
        if (transfer) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          if (inData_i == sum_q) begin
            loadDone_d = 1'b1;
            ckErr_d    = 1'b0;
          end else begin
            loadDone_d = 1'b0;
            ckErr_d    = 1'b1;
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset clearing everything
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      elemCnt_q  <= '0;
      colCnt_q   <= '0;
      section_q  <= SEC_X;
      gate_q     <= 2'd0;
      colData_q  <= '0;
      colAddrX_q <= '0;
      colAddrY_q <= '0;
      busy_q     <= 1'b0;
      loadDone_q <= 1'b0;
`ifdef WLOAD_CHECKSUM_EN
      sum_q      <= '0;
      ckErr_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      elemCnt_q  <= elemCnt_d;
      colCnt_q   <= colCnt_d;
      section_q  <= section_d;
      gate_q     <= gate_d;
      colData_q  <= colData_d;
      colAddrX_q <= colAddrX_d;
      colAddrY_q <= colAddrY_d;
      busy_q     <= busy_d;
      loadDone_q <= loadDone_d;
`ifdef WLOAD_CHECKSUM_EN
      sum_q      <= sum_d;
      ckErr_q    <= ckErr_d;
`endif
    end
  end

endmodule
